// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings for the SRAM port arbiter: FSM states, grant codes, wait counter width.
// The round-robin tie-break is built only when SRAM_ARB_ROUND_ROBIN_EN is defined.
package sram_port_arbiter_pkg;

  localparam int unsigned WAIT_W = 3;

  localparam logic [1:0] SRAM_ARB_IDLE = 2'd0;
  localparam logic [1:0] SRAM_ARB_RD   = 2'd1;
  localparam logic [1:0] SRAM_ARB_WR   = 2'd2;
  localparam logic [1:0] SRAM_ARB_DONE = 2'd3;

  typedef logic grant_t;

  localparam grant_t GRANT_IF  = 1'b0;
  localparam grant_t GRANT_MEM = 1'b1;

  function automatic logic [WAIT_W-1:0] wait_init(input int unsigned cycles);
    return WAIT_W'(cycles);
  endfunction

endpackage

// File: rtl/sram_access_seq.sv
// SRAM cycle sequencer: RD/WR/DONE states, wait-state counter and pad strobe drive.
// Works from request fields already latched by the arbiter above it.
module sram_access_seq
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                start_we_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] sel_i,
  output logic                idle_o,
  output logic                sample_o,
  output logic                done_o,
  output logic [ADDR_W-1:0]   sram_addr_o,
  output logic [DATA_W-1:0]   sram_dq_o,
  output logic                sram_dq_oe_o,
  output logic                sram_ce_n_o,
  output logic                sram_oe_n_o,
  output logic                sram_we_n_o,
  output logic [DATA_W/8-1:0] sram_be_n_o
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [WAIT_W-1:0] r_cnt;
  logic [WAIT_W-1:0] w_cnt_next;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      SRAM_ARB_IDLE: begin
        if (start_i) begin
          w_state_next = start_we_i ? SRAM_ARB_WR : SRAM_ARB_RD;
          w_cnt_next   = wait_init(WAIT_CYCLES);
        end
      end
      SRAM_ARB_RD, SRAM_ARB_WR: begin
        if (r_cnt == '0) begin
          w_state_next = SRAM_ARB_DONE;
        end else begin
          w_cnt_next = r_cnt - WAIT_W'(1);
        end
      end
      SRAM_ARB_DONE: w_state_next = SRAM_ARB_IDLE;
      default:       w_state_next = SRAM_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SRAM_ARB_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Strobes decode straight from the state so a reset releases them on the very next edge.
  always_comb begin
    sram_ce_n_o  = 1'b1;
    sram_oe_n_o  = 1'b1;
    sram_we_n_o  = 1'b1;
    sram_be_n_o  = '1;
    sram_dq_oe_o = 1'b0;
    case (r_state)
      SRAM_ARB_RD: begin
        sram_ce_n_o = 1'b0;
        sram_oe_n_o = 1'b0;
        sram_be_n_o = '0;
      end
      SRAM_ARB_WR: begin
        sram_ce_n_o  = 1'b0;
        sram_we_n_o  = 1'b0;
        sram_be_n_o  = ~sel_i;
        sram_dq_oe_o = 1'b1;
      end
      SRAM_ARB_DONE: begin
        // Write hold cycle: we_n rises while chip select, data and address stay put.
        if (we_i) begin
          sram_ce_n_o  = 1'b0;
          sram_be_n_o  = ~sel_i;
          sram_dq_oe_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign sram_addr_o = addr_i;
  assign sram_dq_o   = wdata_i;

  assign idle_o   = (r_state == SRAM_ARB_IDLE);
  assign sample_o = (r_state == SRAM_ARB_RD) && (r_cnt == '0);
  assign done_o   = (r_state == SRAM_ARB_DONE);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one asynchronous SRAM between the IF and MEM ports; MEM has priority unless
// SRAM_ARB_ROUND_ROBIN_EN is defined, in which case ties alternate starting with MEM.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [31:0]         if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_ack_o,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [DATA_W/8-1:0] mem_sel_i,
  input  logic [31:0]         mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_ack_o,
  output logic                stall_req_o,
  output logic [ADDR_W-1:0]   sram_addr_o,
  input  logic [DATA_W-1:0]   sram_dq_i,
  output logic [DATA_W-1:0]   sram_dq_o,
  output logic                sram_dq_oe_o,
  output logic                sram_ce_n_o,
  output logic                sram_oe_n_o,
  output logic                sram_we_n_o,
  output logic [DATA_W/8-1:0] sram_be_n_o
);

  logic w_idle;
  logic w_sample;
  logic w_done;
  logic w_grant_mem;
  logic w_grant_if;
  logic w_start;

  grant_t              r_grant;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W/8-1:0] r_sel;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_mem_rdata;

  // Byte-offset bits and bits above the SRAM window are don't-care.
  logic w_unused_addr;
  assign w_unused_addr = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0],
                           mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  grant_t r_last_grant;

  always_comb begin
    w_grant_mem = 1'b0;
    w_grant_if  = 1'b0;
    if (w_idle) begin
      if (mem_req_i && if_req_i) begin
        w_grant_mem = (r_last_grant == GRANT_IF);
        w_grant_if  = ~w_grant_mem;
      end else begin
        w_grant_mem = mem_req_i;
        w_grant_if  = if_req_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= GRANT_IF;
    end else if (w_start) begin
      r_last_grant <= w_grant_mem ? GRANT_MEM : GRANT_IF;
    end
  end
`else
  assign w_grant_mem = w_idle & mem_req_i;
  assign w_grant_if  = w_idle & if_req_i & ~mem_req_i;
`endif

  assign w_start = w_grant_mem | w_grant_if;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant <= GRANT_IF;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_sel   <= '0;
      r_wdata <= '0;
    end else if (w_start) begin
      r_grant <= w_grant_mem ? GRANT_MEM : GRANT_IF;
      r_we    <= w_grant_mem & mem_we_i;
      r_addr  <= w_grant_mem ? mem_addr_i[ADDR_W+1:2] : if_addr_i[ADDR_W+1:2];
      r_sel   <= w_grant_mem ? mem_sel_i : '1;
      r_wdata <= w_grant_mem ? mem_wdata_i : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else if (w_sample) begin
      if (r_grant == GRANT_IF) begin
        r_if_rdata <= sram_dq_i;
      end else begin
        r_mem_rdata <= sram_dq_i;
      end
    end
  end

  sram_access_seq #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_seq (
    .clk          (clk),
    .rst          (rst),
    .start_i      (w_start),
    .start_we_i   (w_grant_mem & mem_we_i),
    .we_i         (r_we),
    .addr_i       (r_addr),
    .wdata_i      (r_wdata),
    .sel_i        (r_sel),
    .idle_o       (w_idle),
    .sample_o     (w_sample),
    .done_o       (w_done),
    .sram_addr_o  (sram_addr_o),
    .sram_dq_o    (sram_dq_o),
    .sram_dq_oe_o (sram_dq_oe_o),
    .sram_ce_n_o  (sram_ce_n_o),
    .sram_oe_n_o  (sram_oe_n_o),
    .sram_we_n_o  (sram_we_n_o),
    .sram_be_n_o  (sram_be_n_o)
  );

  assign if_ack_o    = w_done & (r_grant == GRANT_IF);
  assign mem_ack_o   = w_done & (r_grant == GRANT_MEM);
  assign if_rdata_o  = r_if_rdata;
  assign mem_rdata_o = r_mem_rdata;
  assign stall_req_o = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a WAIT_CYCLES=1 instance for the main scenarios and a
// WAIT_CYCLES=0 instance for back-to-back reads, both backed by one behavioural SRAM.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic [19:0] sram_addr;
  logic [31:0] sram_dq_i;
  logic [31:0] sram_dq_o;
  logic        sram_dq_oe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [3:0]  sram_be_n;

  // Second instance (no wait states), IF port only.
  logic        if0_req;
  logic [31:0] if0_addr;
  logic [31:0] if0_rdata;
  logic        if0_ack;
  logic        mem0_req;
  logic [31:0] mem0_rdata;
  logic        mem0_ack;
  logic        stall0;
  logic [19:0] addr0;
  logic [31:0] dq0_i;
  logic [31:0] dq0_o;
  logic        dq0_oe;
  logic        ce0_n;
  logic        oe0_n;
  logic        we0_n;
  logic [3:0]  be0_n;

  logic [31:0] mem [0:1023];

  int n_checks = 0;
  int n_errors = 0;

  logic unused_tb;
  assign unused_tb = ^{sram_addr[19:10], addr0[19:10], mem0_rdata, mem0_ack, stall0, dq0_o,
                       dq0_oe, we0_n, be0_n};

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .ADDR_W      (20),
    .DATA_W      (32),
    .WAIT_CYCLES (1)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_i     (if_req),
    .if_addr_i    (if_addr),
    .if_rdata_o   (if_rdata),
    .if_ack_o     (if_ack),
    .mem_req_i    (mem_req),
    .mem_we_i     (mem_we),
    .mem_sel_i    (mem_sel),
    .mem_addr_i   (mem_addr),
    .mem_wdata_i  (mem_wdata),
    .mem_rdata_o  (mem_rdata),
    .mem_ack_o    (mem_ack),
    .stall_req_o  (stall),
    .sram_addr_o  (sram_addr),
    .sram_dq_i    (sram_dq_i),
    .sram_dq_o    (sram_dq_o),
    .sram_dq_oe_o (sram_dq_oe),
    .sram_ce_n_o  (sram_ce_n),
    .sram_oe_n_o  (sram_oe_n),
    .sram_we_n_o  (sram_we_n),
    .sram_be_n_o  (sram_be_n)
  );

  sram_port_arbiter #(
    .ADDR_W      (20),
    .DATA_W      (32),
    .WAIT_CYCLES (0)
  ) u_dut0 (
    .clk          (clk),
    .rst          (rst),
    .if_req_i     (if0_req),
    .if_addr_i    (if0_addr),
    .if_rdata_o   (if0_rdata),
    .if_ack_o     (if0_ack),
    .mem_req_i    (mem0_req),
    .mem_we_i     (1'b0),
    .mem_sel_i    (4'h0),
    .mem_addr_i   (32'h0),
    .mem_wdata_i  (32'h0),
    .mem_rdata_o  (mem0_rdata),
    .mem_ack_o    (mem0_ack),
    .stall_req_o  (stall0),
    .sram_addr_o  (addr0),
    .sram_dq_i    (dq0_i),
    .sram_dq_o    (dq0_o),
    .sram_dq_oe_o (dq0_oe),
    .sram_ce_n_o  (ce0_n),
    .sram_oe_n_o  (oe0_n),
    .sram_we_n_o  (we0_n),
    .sram_be_n_o  (be0_n)
  );

  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 32'h0;
  assign dq0_i     = (!ce0_n && !oe0_n) ? mem[addr0[9:0]] : 32'h0;

  // SRAM model: contents committed on the rising edge of we_n while chip select is low.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0]     = 32'hA5A50001;
    mem[1]     = 32'h5A5A0002;
    mem[2]     = 32'h11223344;
    mem[10'h100] = 32'h3C011234;
    forever begin
      @(posedge sram_we_n);
      if (sram_ce_n === 1'b0) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_be_n[b] === 1'b0) mem[sram_addr[9:0]][8*b +: 8] = sram_dq_o[8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
    if0_req = 1'b0; if0_addr = 32'h0; mem0_req = 1'b0;
    repeat (2) nc();

    // Reset state
    chk("rst_ce_n", 32'(sram_ce_n), 32'h1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'h1);
    chk("rst_we_n", 32'(sram_we_n), 32'h1);
    chk("rst_be_n", 32'(sram_be_n), 32'hF);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'h0);
    chk("rst_addr", 32'(sram_addr), 32'h0);
    chk("rst_if_ack", 32'(if_ack), 32'h0);
    chk("rst_mem_ack", 32'(mem_ack), 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_ce0_n", 32'(ce0_n), 32'h1);
    rst = 1'b0;
    nc();

    // Tie straight after reset: MEM wins in both arbitration modes
    if_req = 1'b1; if_addr = 32'h400;
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h8;
    #1 chk("tie1_c0_stall", 32'(stall), 32'h1);
    nc(); chk("tie1_c1_addr", 32'(sram_addr), 32'h2);
    chk("tie1_c1_oe_n", 32'(sram_oe_n), 32'h0);
    nc();
    nc(); chk("tie1_c3_mem_ack", 32'(mem_ack), 32'h1);
    chk("tie1_c3_mem_rdata", mem_rdata, 32'h11223344);
    chk("tie1_c3_if_ack", 32'(if_ack), 32'h0);
    chk("tie1_c3_stall", 32'(stall), 32'h1);
    mem_req = 1'b0;
    nc(); chk("tie1_c4_ce_n", 32'(sram_ce_n), 32'h1);
    chk("tie1_c4_stall", 32'(stall), 32'h1);
    chk("tie1_c4_mem_ack", 32'(mem_ack), 32'h0);
    nc(); chk("tie1_c5_addr", 32'(sram_addr), 32'h100);
    nc();
    nc(); chk("tie1_c7_if_ack", 32'(if_ack), 32'h1);
    chk("tie1_c7_if_rdata", if_rdata, 32'h3C011234);
    chk("tie1_c7_stall", 32'(stall), 32'h0);
    if_req = 1'b0;
    nc();

    // Single IF read; address bits [1:0] and above bit 21 must be ignored
    if_req = 1'b1; if_addr = 32'hFFC00403;
    #1 chk("rd_c0_stall", 32'(stall), 32'h1);
    chk("rd_c0_oe_n", 32'(sram_oe_n), 32'h1);
    nc(); chk("rd_c1_oe_n", 32'(sram_oe_n), 32'h0);
    chk("rd_c1_ce_n", 32'(sram_ce_n), 32'h0);
    chk("rd_c1_be_n", 32'(sram_be_n), 32'h0);
    chk("rd_c1_dq_oe", 32'(sram_dq_oe), 32'h0);
    chk("rd_c1_addr", 32'(sram_addr), 32'h100);
    nc(); chk("rd_c2_oe_n", 32'(sram_oe_n), 32'h0);
    chk("rd_c2_stall", 32'(stall), 32'h1);
    chk("rd_c2_if_ack", 32'(if_ack), 32'h0);
    nc(); chk("rd_c3_if_ack", 32'(if_ack), 32'h1);
    chk("rd_c3_if_rdata", if_rdata, 32'h3C011234);
    chk("rd_c3_stall", 32'(stall), 32'h0);
    chk("rd_c3_oe_n", 32'(sram_oe_n), 32'h1);
    chk("rd_c3_ce_n", 32'(sram_ce_n), 32'h1);
    if_req = 1'b0;
    nc(); chk("rd_c4_if_ack", 32'(if_ack), 32'h0);

    // Store with partial byte select; inputs change after grant
    mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h8;
    mem_wdata = 32'hDEADBEEF;
    #1 chk("st_c0_stall", 32'(stall), 32'h1);
    nc(); chk("st_c1_we_n", 32'(sram_we_n), 32'h0);
    chk("st_c1_be_n", 32'(sram_be_n), 32'hC);
    chk("st_c1_dq_oe", 32'(sram_dq_oe), 32'h1);
    chk("st_c1_dq_o", sram_dq_o, 32'hDEADBEEF);
    chk("st_c1_addr", 32'(sram_addr), 32'h2);
    chk("st_c1_oe_n", 32'(sram_oe_n), 32'h1);
    mem_wdata = 32'h0; mem_addr = 32'h40; mem_sel = 4'hF;
    nc(); chk("st_c2_we_n", 32'(sram_we_n), 32'h0);
    chk("st_c2_dq_o", sram_dq_o, 32'hDEADBEEF);
    chk("st_c2_addr", 32'(sram_addr), 32'h2);
    chk("st_c2_be_n", 32'(sram_be_n), 32'hC);
    nc(); chk("st_c3_mem_ack", 32'(mem_ack), 32'h1);
    chk("st_c3_we_n", 32'(sram_we_n), 32'h1);
    chk("st_c3_ce_n", 32'(sram_ce_n), 32'h0);
    chk("st_c3_dq_oe", 32'(sram_dq_oe), 32'h1);
    chk("st_c3_dq_o", sram_dq_o, 32'hDEADBEEF);
    chk("st_c3_addr", 32'(sram_addr), 32'h2);
    mem_req = 1'b0; mem_we = 1'b0;
    nc(); chk("st_c4_ce_n", 32'(sram_ce_n), 32'h1);
    chk("st_c4_dq_oe", 32'(sram_dq_oe), 32'h0);
    chk("st_c4_mem_ack", 32'(mem_ack), 32'h0);

    // Readback of the stored word
    mem_req = 1'b1; mem_addr = 32'h8;
    nc(); nc();
    nc(); chk("rb_c3_mem_ack", 32'(mem_ack), 32'h1);
    chk("rb_c3_mem_rdata", mem_rdata, 32'h1122BEEF);
    mem_req = 1'b0;
    nc();

    // Second tie after a MEM grant: round-robin now favours IF
    if_req = 1'b1; if_addr = 32'h4;
    mem_req = 1'b1; mem_addr = 32'h0;
    nc(); nc();
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    nc(); chk("tie2_c3_if_ack", 32'(if_ack), 32'h1);
    chk("tie2_c3_if_rdata", if_rdata, 32'h5A5A0002);
    chk("tie2_c3_mem_ack", 32'(mem_ack), 32'h0);
    chk("tie2_c3_stall", 32'(stall), 32'h1);
    if_req = 1'b0;
    nc(); nc(); nc();
    nc(); chk("tie2_c7_mem_ack", 32'(mem_ack), 32'h1);
    chk("tie2_c7_mem_rdata", mem_rdata, 32'hA5A50001);
    mem_req = 1'b0;
`else
    nc(); chk("tie2_c3_mem_ack", 32'(mem_ack), 32'h1);
    chk("tie2_c3_mem_rdata", mem_rdata, 32'hA5A50001);
    chk("tie2_c3_if_ack", 32'(if_ack), 32'h0);
    chk("tie2_c3_stall", 32'(stall), 32'h1);
    mem_req = 1'b0;
    nc(); nc(); nc();
    nc(); chk("tie2_c7_if_ack", 32'(if_ack), 32'h1);
    chk("tie2_c7_if_rdata", if_rdata, 32'h5A5A0002);
    if_req = 1'b0;
`endif
    nc();

    // Reset during the second RD cycle aborts the access
    if_req = 1'b1; if_addr = 32'h400;
    nc();
    nc(); chk("ab_c2_oe_n", 32'(sram_oe_n), 32'h0);
    rst = 1'b1;
    nc(); chk("ab_ce_n", 32'(sram_ce_n), 32'h1);
    chk("ab_oe_n", 32'(sram_oe_n), 32'h1);
    chk("ab_if_ack", 32'(if_ack), 32'h0);
    chk("ab_if_rdata", if_rdata, 32'h0);
    rst = 1'b0; if_req = 1'b0;
    nc();

    // Fresh request after reset, then req held through ack with a new address
    if_req = 1'b1; if_addr = 32'h8;
    nc(); nc();
    nc(); chk("fr_c3_if_ack", 32'(if_ack), 32'h1);
    chk("fr_c3_if_rdata", if_rdata, 32'h1122BEEF);
    if_addr = 32'h0;
    nc(); chk("hd_c4_if_ack", 32'(if_ack), 32'h0);
    chk("hd_c4_ce_n", 32'(sram_ce_n), 32'h1);
    chk("hd_c4_stall", 32'(stall), 32'h1);
    nc(); chk("hd_c5_addr", 32'(sram_addr), 32'h0);
    chk("hd_c5_oe_n", 32'(sram_oe_n), 32'h0);
    nc();
    nc(); chk("hd_c7_if_ack", 32'(if_ack), 32'h1);
    chk("hd_c7_if_rdata", if_rdata, 32'hA5A50001);
    if_req = 1'b0;
    nc();

    // WAIT_CYCLES=0: back-to-back reads of 0x0 and 0x4
    if0_req = 1'b1; if0_addr = 32'h0;
    #1 chk("w0_c0_ack", 32'(if0_ack), 32'h0);
    nc(); chk("w0_c1_oe_n", 32'(oe0_n), 32'h0);
    chk("w0_c1_ack", 32'(if0_ack), 32'h0);
    nc(); chk("w0_c2_ack", 32'(if0_ack), 32'h1);
    chk("w0_c2_rdata", if0_rdata, 32'hA5A50001);
    if0_addr = 32'h4;
    nc(); chk("w0_c3_ack", 32'(if0_ack), 32'h0);
    chk("w0_c3_ce_n", 32'(ce0_n), 32'h1);
    nc(); chk("w0_c4_oe_n", 32'(oe0_n), 32'h0);
    chk("w0_c4_addr", 32'(addr0), 32'h1);
    nc(); chk("w0_c5_ack", 32'(if0_ack), 32'h1);
    chk("w0_c5_rdata", if0_rdata, 32'h5A5A0002);
    if0_req = 1'b0;
    nc(); chk("w0_c6_ack", 32'(if0_ack), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Arbitrates one external single-port asynchronous SRAM between two requesters: the instruction-fetch (IF) port and the MEM-stage load/store port.
- Each access is sequenced as a multi-cycle SRAM cycle with configurable wait states. Read data is returned with a one-cycle ack.
- Raises a stall request to CTRL while any requester is waiting.
- Sits between the PC/IF logic, the MEM stage and the board SRAM pins. It replaces ad-hoc structural-conflict handling in the fetch path.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- DATA_W, 32, SRAM data width; byte enables are DATA_W/8 wide.
- WAIT_CYCLES, 1, number of extra strobe cycles per access; legal range 0..7.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- if_req_i  in  1  fetch request; held until if_ack_o.
- if_addr_i  in  32  fetch byte address.
- if_rdata_o  out  DATA_W  fetched word; valid only while if_ack_o=1.
- if_ack_o  out  1  one-cycle completion pulse for IF.
- mem_req_i  in  1  load/store request; held until mem_ack_o.
- mem_we_i  in  1  1=store, 0=load.
- mem_sel_i  in  DATA_W/8  byte select for stores.
- mem_addr_i  in  32  load/store byte address.
- mem_wdata_i  in  DATA_W  store data.
- mem_rdata_o  out  DATA_W  load word; valid only while mem_ack_o=1.
- mem_ack_o  out  1  one-cycle completion pulse for MEM.
- stall_req_o  out  1  to CTRL; combinational (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o).
- sram_addr_o  out  ADDR_W  word address = granted addr[ADDR_W+1:2].
- sram_dq_i  in  DATA_W  data from pad.
- sram_dq_o  out  DATA_W  data to pad.
- sram_dq_oe_o  out  1  pad output enable.
- sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  active-low strobes.
- sram_be_n_o  out  DATA_W/8  active-low byte enables.

Behaviour:
- Reset values: all acks 0, rdata 0, dq_oe 0, ce_n/oe_n/we_n 1, be_n all 1, addr 0, FSM in IDLE, wait counter 0. Reset applied mid-access aborts the access immediately: no ack, strobes high the next edge.
- FSM states: IDLE, RD, WR, DONE.
- IDLE:
  - If mem_req_i is set, grant MEM. Otherwise, if if_req_i is set, grant IF.
  - On grant, latch the address, we, sel and wdata. Load the counter with WAIT_CYCLES.
  - Go to RD, or to WR when MEM is granted with mem_we_i=1.
- RD:
  - ce_n=0, oe_n=0, be_n all 0, dq_oe=0.
  - The counter decrements each cycle. When it is 0, sample sram_dq_i into the granted requester's rdata register and go to DONE.
- WR:
  - ce_n=0, we_n=0, be_n=~sel, dq_oe=1, dq_o=wdata.
  - When the counter is 0, go to DONE.
- DONE:
  - Pulse the granted requester's ack for exactly one cycle.
  - After a read: ce_n=1, oe_n=1. After a write (hold cycle): we_n=1, ce_n=0, dq_oe=1, and data and address unchanged.
  - Next state is always IDLE.
- No grant is made in DONE. A req seen in IDLE after an ack is treated as a new request.
- Timing:
  - Latency req→ack = WAIT_CYCLES+2 cycles when the port is idle.
  - Throughput is one access per WAIT_CYCLES+3 cycles.
- Simultaneous requests: MEM wins; IF waits and stall_req_o stays 1.
- A request arriving during another access waits. Latched values are not affected by input changes after the grant.
- Address bits [1:0] and bits above ADDR_W+1 are ignored.

Optional Feature:
- Macro SRAM_ARB_ROUND_ROBIN_EN.
- Defined: a last-grant flag is kept. When both requesters are pending in IDLE, the port not granted last wins. The flag resets to IF, so MEM wins the first tie.
- Undefined: fixed MEM-over-IF priority and no extra state.

Decomposition:
- Shared package/defines.vh: state encodings SRAM_ARB_IDLE/RD/WR/DONE, GRANT_IF/GRANT_MEM codes, WAIT_W=3.
- One natural sub-module, sram_access_seq. It holds the RD/WR/DONE sequencing, wait counter and pin drive. The top level keeps the grant logic, latches, per-port rdata/ack and stall.

Test Plan:
- Single IF read, WAIT_CYCLES=1, SRAM word 0x100=0x3C011234, if_addr 0x400 → sram_addr 0x100 with oe_n low cycles 1–2, if_ack at cycle 3, if_rdata 0x3C011234, stall_req high cycles 0–2.
- MEM store sel=4'b0011, addr 0x8, wdata 0xDEADBEEF → we_n low 2 cycles, be_n=4'b1100, hold cycle with we_n=1 and dq_oe=1; readback of 0x8 gives 0x????BEEF with the upper bytes unchanged.
- IF and MEM load requested in the same cycle → MEM acked at cycle 3, IF granted at cycle 4 and acked at cycle 7; under SRAM_ARB_ROUND_ROBIN_EN a second tie grants IF first.
- WAIT_CYCLES=0 back-to-back IF reads of 0x0 and 0x4 → acks at cycles 2 and 5, correct data each time.
- rst asserted in the second RD cycle → next edge: strobes high, no ack; a fresh request after reset completes normally.
- Requester holds req through ack and then keeps it with a new address → a second access starts in the IDLE cycle after DONE and returns the new word.
